if_stage: RTL and testbench

Instruction-fetch control block for the five-stage ARM pipeline. Owns the program counter and drives the instruction memory address. Registers the returned 32-bit instruction and its PC+4 into the IF/ID pipeline register, which feeds decode. Also handles hazard freeze and branch redirect/flush from the execute stage.

---
 rtl/if_stage_pkg.sv | 29 ++
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage_pc_register.sv | 22 ++
 rtl/if_stage.sv | 66 ++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants, types and helpers for the five-stage ARM pipeline.
// Holds widths, reset PC, PC step, NOP encoding and the IF/ID register layout.
package if_stage_pkg;

  localparam int ADDRESS_LEN = 32;
  localparam int INSTR_LEN   = 32;

  typedef logic [ADDRESS_LEN-1:0] addr_t;
  typedef logic [INSTR_LEN-1:0]   instr_t;

  localparam addr_t  RESET_PC  = '0;
  localparam addr_t  PC_STEP   = addr_t'(4);
  localparam instr_t NOP_INSTR = '0;

  typedef struct packed {
    logic   vld;
    addr_t  pc;
    instr_t instr;
  } ifid_t;

  // Reset and flush share one image: a bubble carrying NOP and a zero PC.
  localparam ifid_t IFID_CLEAR = '{vld: 1'b0, pc: '0, instr: NOP_INSTR};

  // Branch targets are word addresses; misaligned low bits are discarded.
  function automatic addr_t word_align(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface if_stage_if;
  import if_stage_pkg::*;

  logic   freeze;
  logic   branch_taken;
  addr_t  branch_address;
  addr_t  imem_address;
  instr_t imem_instruction;
  addr_t  pc_out;
  instr_t instruction_out;
  logic   valid_out;

  modport master (
    input  freeze, branch_taken, branch_address, imem_instruction,
    output imem_address, pc_out, instruction_out, valid_out
  );

  modport slave (
    output freeze, branch_taken, branch_address, imem_instruction,
    input  imem_address, pc_out, instruction_out, valid_out
  );

endinterface

// File: rtl/if_stage_pc_register.sv
// pc_register: loadable register with asynchronous active-high reset to RESET_VAL.
// Latency 1 edge from d to q when load_en is high; holds otherwise.
module pc_register #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC drives imem, instruction lands in IF/ID 1 edge later; freeze stalls, branch redirects+flushes.
// Optional perf counters fetch_count/flush_count exist only when IF_PERF_COUNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  addr_t pc;
  addr_t pc_plus4;
  addr_t pc_d;
  logic  pc_ld;
  ifid_t ifid_q;

  assign pc_plus4 = pc + PC_STEP;
  assign pc_d     = bus.branch_taken ? word_align(bus.branch_address) : pc_plus4;
  // Redirect must override a stall, so branch_taken forces the load.
  assign pc_ld    = bus.branch_taken | ~bus.freeze;

  pc_register #(
    .WIDTH     (ADDRESS_LEN),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load_en (pc_ld),
    .d       (pc_d),
    .q       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= IFID_CLEAR;
    end else if (bus.branch_taken) begin
      ifid_q <= IFID_CLEAR;
    end else if (!bus.freeze) begin
      ifid_q <= '{vld: 1'b1, pc: pc_plus4, instr: bus.imem_instruction};
    end
  end

  assign bus.imem_address    = pc;
  assign bus.pc_out          = ifid_q.pc;
  assign bus.instruction_out = ifid_q.instr;
  assign bus.valid_out       = ifid_q.vld;

`ifdef IF_PERF_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else if (bus.branch_taken) begin
      flush_count <= flush_count + 32'd1;
    end else if (!bus.freeze) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomised and directed fetch-stage bench with an in-bench reference model.
// Perf counter checks compile in only when IF_PERF_COUNT_EN is defined.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_PERF_COUNT_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  // Bench instruction memory: a few fixed words, everything else derived from the address.
  function automatic instr_t mem_rd(input addr_t a);
    case (a)
      32'h0000_0000: return 32'hE3A0_0015;
      32'h0000_0004: return 32'hE3A0_1A01;
      32'h0000_001C: return 32'hEAFF_FFFF;
      default:       return a ^ 32'hE1A0_0000;
    endcase
  endfunction

  assign bus.imem_instruction = mem_rd(bus.imem_address);

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage must hold after each edge.
  logic [31:0] m_pc, m_pcout, m_instr, m_fetch, m_flush;
  logic        m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_pcout = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_fetch = 32'h0; m_flush = 32'h0;
    end else if (bus.branch_taken) begin
      m_pc    = {bus.branch_address[31:2], 2'b00};
      m_valid = 1'b0; m_instr = 32'h0; m_pcout = 32'h0;
      m_flush = m_flush + 1;
    end else if (!bus.freeze) begin
      m_instr = mem_rd(m_pc);
      m_pcout = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fetch = m_fetch + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model imem_address",    bus.imem_address,    m_pc);
      chk("model pc_out",          bus.pc_out,          m_pcout);
      chk("model instruction_out", bus.instruction_out, m_instr);
      chk("model valid_out",       {31'd0, bus.valid_out}, {31'd0, m_valid});
`ifdef IF_PERF_COUNT_EN
      chk("model fetch_count", fetch_count, m_fetch);
      chk("model flush_count", flush_count, m_flush);
`endif
    end
  end

  task automatic cyc(input logic f, input logic b, input addr_t a);
    bus.freeze         = f;
    bus.branch_taken   = b;
    bus.branch_address = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_address = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset imem_address", bus.imem_address, 32'h0);
    chk("reset pc_out",       bus.pc_out, 32'h0);
    chk("reset instr",        bus.instruction_out, 32'h0);
    chk("reset valid",        {31'd0, bus.valid_out}, 32'd0);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Free run from address 0.
    cyc(1'b0, 1'b0, '0);
    chk("run1 instr",  bus.instruction_out, 32'hE3A0_0015);
    chk("run1 pc_out", bus.pc_out, 32'h4);
    chk("run1 valid",  {31'd0, bus.valid_out}, 32'd1);
    chk("run1 addr",   bus.imem_address, 32'h4);
    cyc(1'b0, 1'b0, '0);
    chk("run2 instr",  bus.instruction_out, 32'hE3A0_1A01);
    chk("run2 pc_out", bus.pc_out, 32'h8);
    chk("run2 addr",   bus.imem_address, 32'h8);

    // Freeze for 3 edges at PC=0x8.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0000_0030);
      chk("frz addr",   bus.imem_address, 32'h8);
      chk("frz instr",  bus.instruction_out, 32'hE3A0_1A01);
      chk("frz pc_out", bus.pc_out, 32'h8);
    end
    cyc(1'b0, 1'b0, '0);
    chk("resume instr",  bus.instruction_out, 32'hE1A0_0008);
    chk("resume pc_out", bus.pc_out, 32'hC);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("pre-branch addr", bus.imem_address, 32'h14);

    // Branch to 0x1C: one bubble, then the target.
    cyc(1'b0, 1'b1, 32'h0000_001C);
    chk("br addr",   bus.imem_address, 32'h1C);
    chk("br valid",  {31'd0, bus.valid_out}, 32'd0);
    chk("br instr",  bus.instruction_out, 32'h0);
`ifdef IF_PERF_COUNT_EN
    chk("perf fetch_count", fetch_count, 32'd5);
    chk("perf flush_count", flush_count, 32'd1);
`endif
    cyc(1'b0, 1'b0, '0);
    chk("tgt instr",  bus.instruction_out, 32'hEAFF_FFFF);
    chk("tgt pc_out", bus.pc_out, 32'h20);
    chk("tgt valid",  {31'd0, bus.valid_out}, 32'd1);

    // Branch wins over freeze; misaligned target bits dropped.
    cyc(1'b1, 1'b1, 32'h0000_0041);
    chk("brfrz addr",  bus.imem_address, 32'h40);
    chk("brfrz valid", {31'd0, bus.valid_out}, 32'd0);
    chk("brfrz instr", bus.instruction_out, 32'h0);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap pre addr", bus.imem_address, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, '0);
    chk("wrap addr",   bus.imem_address, 32'h0);
    chk("wrap pc_out", bus.pc_out, 32'h0);
    chk("wrap instr",  bus.instruction_out, 32'h1E5F_FFFC);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic  f, b;
      addr_t a;
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : addr_t'($urandom);
      cyc(f, b, a);
    end

    // Reset in the middle of a freeze+branch cycle.
    bus.freeze = 1'b1; bus.branch_taken = 1'b1; bus.branch_address = 32'h0000_0100;
    #2 rst = 1'b1;
    #1;
    chk("midrst addr",  bus.imem_address, 32'h0);
    chk("midrst valid", {31'd0, bus.valid_out}, 32'd0);
    chk("midrst instr", bus.instruction_out, 32'h0);
    chk("midrst pc_out", bus.pc_out, 32'h0);
`ifdef IF_PERF_COUNT_EN
    chk("midrst fetch_count", fetch_count, 32'd0);
    chk("midrst flush_count", flush_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
    chk("restart instr",  bus.instruction_out, 32'hE3A0_0015);
    chk("restart pc_out", bus.pc_out, 32'h4);
    chk("restart addr",   bus.imem_address, 32'h4);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
